// File: rtl/mau_fp_addsub.sv
// Multi-cycle sign/magnitude floating-point add/subtract for the MAU datapath.
// Five-state sequencer: IDLE -> ALIGN -> ADD -> NORM -> OUT, one operation in flight.
module mau_fp_addsub #(
   parameter int MW = 18,
   parameter int EW = 5
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          op,
   input  logic [MW-1:0] a_mantissa,
   input  logic [EW-1:0] a_exponent,
   input  logic          a_sign,
   input  logic [MW-1:0] b_mantissa,
   input  logic [EW-1:0] b_exponent,
   input  logic          b_sign,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [MW-1:0] c_mantissa,
   output logic [EW-1:0] c_exponent,
   output logic          c_sign,
   output logic          c_zero,
   output logic          c_ovf
);

   typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_OUT} state_t;

   state_t        state, state_nx;
   logic [MW-1:0] l_m, s_m;
   logic [EW-1:0] l_e, delta;
   logic          l_s, s_s;
   logic [MW:0]   sum, sum_c;
   logic          sum_s, sum_s_c;
   logic [MW-1:0] n_m;
   logic [EW-1:0] n_e;
   logic          n_s, n_z, n_v;
   logic [31:0]   lz, sh;
   logic          a_big;

   function automatic logic [31:0] lzc(input logic [MW-1:0] v);
      logic [31:0] n;
      n = 32'(MW);
      for (int i = 0; i < MW; i++)
         if (v[i]) n = 32'(MW - 1 - i);
      return n;
   endfunction

   assign in_ready = (state == S_IDLE);
   assign out_valid = (state == S_OUT);
   assign a_big = (a_exponent >= b_exponent);

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (in_valid) state_nx = S_ALIGN;
         S_ALIGN: state_nx = S_ADD;
         S_ADD:   state_nx = S_NORM;
         S_NORM:  state_nx = S_OUT;
         S_OUT:   if (out_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Unlike signs: the result takes the sign of whichever magnitude is larger,
   // which may be the aligned small operand when inputs are unnormalised.
   always_comb begin
      sum_c   = '0;
      sum_s_c = l_s;
      if (l_s == s_s)
         sum_c = {1'b0, l_m} + {1'b0, s_m};
      else if (l_m >= s_m)
         sum_c = {1'b0, l_m} - {1'b0, s_m};
      else begin
         sum_c   = {1'b0, s_m} - {1'b0, l_m};
         sum_s_c = s_s;
      end
   end

   always_comb begin
      n_m = '0;
      n_e = '0;
      n_s = 1'b0;
      n_z = 1'b0;
      n_v = 1'b0;
      lz  = lzc(sum[MW-1:0]);
      sh  = (lz < 32'(l_e)) ? lz : 32'(l_e);
      if (sum == '0)
         n_z = 1'b1;
      else if (sum[MW]) begin
         n_s = sum_s;
         if (l_e != '1) begin
            n_m = sum[MW:1];
            n_e = l_e + 1'b1;
         end else begin
            n_m = '1;
            n_e = '1;
            n_v = 1'b1;
         end
      end else begin
         n_s = sum_s;
         n_m = sum[MW-1:0] << sh;
         n_e = l_e - EW'(sh);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         l_m <= '0; l_e <= '0; l_s <= 1'b0;
         s_m <= '0; s_s <= 1'b0; delta <= '0;
         sum <= '0; sum_s <= 1'b0;
         c_mantissa <= '0; c_exponent <= '0; c_sign <= 1'b0;
         c_zero <= 1'b0; c_ovf <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (in_valid) begin
               c_zero <= 1'b0;
               c_ovf  <= 1'b0;
               if (a_big) begin
                  l_m <= a_mantissa; l_e <= a_exponent; l_s <= a_sign;
                  s_m <= b_mantissa; s_s <= b_sign ^ op;
                  delta <= a_exponent - b_exponent;
               end else begin
                  l_m <= b_mantissa; l_e <= b_exponent; l_s <= b_sign ^ op;
                  s_m <= a_mantissa; s_s <= a_sign;
                  delta <= b_exponent - a_exponent;
               end
            end
            S_ALIGN: s_m <= (32'(delta) >= 32'(MW)) ? '0 : (s_m >> delta);
            S_ADD: begin
               sum   <= sum_c;
               sum_s <= sum_s_c;
            end
            S_NORM: begin
               c_mantissa <= n_m;
               c_exponent <= n_e;
               c_sign     <= n_s;
               c_zero     <= n_z;
               c_ovf      <= n_v;
            end
            default: ;
         endcase
      end
   end

endmodule
